// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - instruction decoder feeding a FIFO of decoded entries
module decode_queue #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int ZEXT_LOGIC = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5:0]                 out_opcode,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_shamt,
  output logic [5:0]                 out_funct,
  output logic [25:0]                out_addr,
  output logic [XLEN-1:0]            out_imm,
  output logic [1:0]                 out_type,
  output logic                       out_jump,
  output logic                       out_branch,
  output logic                       out_load,
  output logic                       out_store,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Decoded entries; the raw word is kept because every field is a slice of it.
  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] imm_mem   [DEPTH];
  logic [1:0]      type_mem  [DEPTH];
  logic [4:0]      flag_mem  [DEPTH];

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic [5:0]      dec_opcode;
  logic [1:0]      dec_type;
  logic            dec_zext;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_flags;
  logic            push;
  logic            pop;

  assign dec_opcode = in_instr[31:26];

  // Classify the incoming opcode into R / I / J / illegal.
  always_comb begin
    dec_type = 2'd3;
    case (dec_opcode)
      6'h00: dec_type = 2'd0;
      6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h1C, 6'h1D,
      6'h23, 6'h2B: dec_type = 2'd1;
      6'h01, 6'h02, 6'h03: dec_type = 2'd2;
      default: dec_type = 2'd3;
    endcase
  end

  // Logical immediates (andi/ori/xori) may be zero-extended; everything else sign-extends.
  always_comb begin
    dec_zext = (ZEXT_LOGIC != 0) &&
               ((dec_opcode == 6'h0C) || (dec_opcode == 6'h0D) || (dec_opcode == 6'h0E));
    if (dec_zext)
      dec_imm = {{(XLEN-16){1'b0}}, in_instr[15:0]};
    else
      dec_imm = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
  end

  // Flag order: jump, branch, load, store, illegal.
  assign dec_flags = {dec_type == 2'd2,
                      (dec_opcode == 6'h04) || (dec_opcode == 6'h05),
                      dec_opcode == 6'h23,
                      dec_opcode == 6'h2B,
                      dec_type == 2'd3};

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Store the decoded result at the write pointer; contents need no reset since count gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      imm_mem[wr_ptr]   <= dec_imm;
      type_mem[wr_ptr]  <= dec_type;
      flag_mem[wr_ptr]  <= dec_flags;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating count of accepted illegal instructions; survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_cnt <= '0;
    else if (push && dec_flags[0] && (illegal_cnt != 16'hFFFF))
      illegal_cnt <= illegal_cnt + 16'd1;
  end

  // Present the head entry, forced to zero whenever the queue is empty.
  always_comb begin
    out_opcode  = '0;
    out_rs      = '0;
    out_rt      = '0;
    out_rd      = '0;
    out_shamt   = '0;
    out_funct   = '0;
    out_addr    = '0;
    out_imm     = '0;
    out_type    = '0;
    out_jump    = 1'b0;
    out_branch  = 1'b0;
    out_load    = 1'b0;
    out_store   = 1'b0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_opcode  = instr_mem[rd_ptr][31:26];
      out_rs      = instr_mem[rd_ptr][25:21];
      out_rt      = instr_mem[rd_ptr][20:16];
      out_rd      = instr_mem[rd_ptr][15:11];
      out_shamt   = instr_mem[rd_ptr][10:6];
      out_funct   = instr_mem[rd_ptr][5:0];
      out_addr    = instr_mem[rd_ptr][25:0];
      out_imm     = imm_mem[rd_ptr];
      out_type    = type_mem[rd_ptr];
      {out_jump, out_branch, out_load, out_store, out_illegal} = flag_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - randomized and directed checks of decode_queue against a queue model
module tb_decode_queue;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic out_ready = 1'b0;

  logic in_ready, out_valid, out_jump, out_branch, out_load, out_store, out_illegal;
  logic [5:0] out_opcode, out_funct;
  logic [4:0] out_rs, out_rt, out_rd, out_shamt;
  logic [25:0] out_addr;
  logic [31:0] out_imm;
  logic [1:0] out_type;
  logic [2:0] count;
  logic [15:0] illegal_cnt;

  logic z_in_ready, z_out_valid, z_jump, z_branch, z_load, z_store, z_illegal;
  logic [5:0] z_opcode, z_funct;
  logic [4:0] z_rs, z_rt, z_rd, z_shamt;
  logic [25:0] z_addr;
  logic [31:0] z_imm;
  logic [1:0] z_type;
  logic [2:0] z_count;
  logic [15:0] z_illegal_cnt;

  logic w_in_ready, w_out_valid, w_jump, w_branch, w_load, w_store, w_illegal;
  logic [5:0] w_opcode, w_funct;
  logic [4:0] w_rs, w_rt, w_rd, w_shamt;
  logic [25:0] w_addr;
  logic [63:0] w_imm;
  logic [1:0] w_type;
  logic [2:0] w_count;
  logic [15:0] w_illegal_cnt;

  decode_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_addr(out_addr), .out_imm(out_imm),
    .out_type(out_type), .out_jump(out_jump), .out_branch(out_branch), .out_load(out_load),
    .out_store(out_store), .out_illegal(out_illegal), .count(count), .illegal_cnt(illegal_cnt)
  );

  decode_queue #(.XLEN(32), .DEPTH(DEPTH), .ZEXT_LOGIC(0)) dut_z0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_instr(in_instr), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_opcode(z_opcode), .out_rs(z_rs), .out_rt(z_rt), .out_rd(z_rd),
    .out_shamt(z_shamt), .out_funct(z_funct), .out_addr(z_addr), .out_imm(z_imm),
    .out_type(z_type), .out_jump(z_jump), .out_branch(z_branch), .out_load(z_load),
    .out_store(z_store), .out_illegal(z_illegal), .count(z_count), .illegal_cnt(z_illegal_cnt)
  );

  decode_queue #(.XLEN(64), .DEPTH(DEPTH), .ZEXT_LOGIC(0)) dut_64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_opcode(w_opcode), .out_rs(w_rs), .out_rt(w_rt), .out_rd(w_rd),
    .out_shamt(w_shamt), .out_funct(w_funct), .out_addr(w_addr), .out_imm(w_imm),
    .out_type(w_type), .out_jump(w_jump), .out_branch(w_branch), .out_load(w_load),
    .out_store(w_store), .out_illegal(w_illegal), .count(w_count), .illegal_cnt(w_illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] mdl_q[$];
  int mdl_ilc = 0;

  logic [5:0] ops [20] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                          6'h0E, 6'h0F, 6'h12, 6'h17, 6'h1C, 6'h1D, 6'h23, 6'h2B, 6'h3F, 6'h06};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_type(input logic [5:0] op);
    if (op == 6'h00) return 2'd0;
    if (op inside {6'h04, 6'h05, [6'h08:6'h0A], [6'h0C:6'h0F], [6'h12:6'h17], 6'h1C, 6'h1D, 6'h23, 6'h2B})
      return 2'd1;
    if (op inside {[6'h01:6'h03]}) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [4:0] m_flags(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    return {m_type(op) == 2'd2, op == 6'h04 || op == 6'h05, op == 6'h23, op == 6'h2B, m_type(op) == 2'd3};
  endfunction

  function automatic logic [63:0] m_imm(input logic [31:0] i, input bit zx, input int xl);
    logic [63:0] v;
    v = {{48{i[15]}}, i[15:0]};
    if (zx && i[31:26] inside {6'h0C, 6'h0D, 6'h0E}) v = {48'd0, i[15:0]};
    if (xl == 32) v[63:32] = '0;
    return v;
  endfunction

  // Compare every output of all three instances against the model's current state.
  task automatic compare_all();
    bit v;
    logic [31:0] h;
    logic [64:0] ef;
    logic [20:0] st;
    v  = (mdl_q.size() != 0);
    h  = v ? mdl_q[0] : 32'd0;
    ef = v ? {h, h[25:0], m_type(h[31:26]), m_flags(h)} : 65'd0;
    st = {v, mdl_q.size() < DEPTH, 3'(mdl_q.size()), 16'(mdl_ilc)};
    check("status", {out_valid, in_ready, count, illegal_cnt}, st);
    check("z_status", {z_out_valid, z_in_ready, z_count, z_illegal_cnt}, st);
    check("w_status", {w_out_valid, w_in_ready, w_count, w_illegal_cnt}, st);
    check("fields", {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_addr, out_type,
                     out_jump, out_branch, out_load, out_store, out_illegal}, ef);
    check("z_fields", {z_opcode, z_rs, z_rt, z_rd, z_shamt, z_funct, z_addr, z_type,
                       z_jump, z_branch, z_load, z_store, z_illegal}, ef);
    check("w_fields", {w_opcode, w_rs, w_rt, w_rd, w_shamt, w_funct, w_addr, w_type,
                       w_jump, w_branch, w_load, w_store, w_illegal}, ef);
    check("imm", out_imm, v ? m_imm(h, 1, 32) : 64'd0);
    check("z_imm", z_imm, v ? m_imm(h, 0, 32) : 64'd0);
    check("w_imm", w_imm, v ? m_imm(h, 0, 64) : 64'd0);
  endtask

  // One clock cycle: drive inputs, check at the falling edge, then advance the model.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    bit do_push, do_pop;
    in_valid = v; in_instr = ins; out_ready = rdy; flush = fl;
    @(negedge clk);
    compare_all();
    do_push = v && (mdl_q.size() < DEPTH) && !fl;
    do_pop  = rdy && (mdl_q.size() != 0) && !fl;
    @(posedge clk);
    #1;
    if (fl) mdl_q.delete();
    else begin
      if (do_pop) void'(mdl_q.pop_front());
      if (do_push) mdl_q.push_back(ins);
    end
    if (do_push && m_type(ins[31:26]) == 2'd3 && mdl_ilc < 65535) mdl_ilc++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r[31:26] = ops[$urandom_range(0, 19)];
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // addi into an empty queue
    cyc(1, 32'h2009FFFF, 0, 0);
    check("addi_type", out_type, 2'd1);
    check("addi_rs_rt", {out_rs, out_rt}, {5'd0, 5'd9});
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    check("addi_flags", {out_jump, out_branch, out_load, out_store, out_illegal}, 5'd0);
    cyc(0, 0, 0, 1);

    // ori under the three parameterizations
    cyc(1, 32'h3409FFFF, 0, 0);
    check("ori_zext", out_imm, 32'h0000FFFF);
    check("ori_sext", z_imm, 32'hFFFFFFFF);
    check("ori_sext64", w_imm, 64'hFFFFFFFFFFFFFFFF);
    cyc(0, 0, 0, 1);

    // fill to DEPTH with a fifth push refused, then one pop with in_valid held
    for (int k = 0; k < 5; k++) cyc(1, 32'h00000020 + k, 0, 0);
    check("full_count", count, 3'd4);
    check("full_ready", in_ready, 1'b0);
    cyc(1, 32'h00000099, 1, 0);
    check("after_pop_count", count, 3'd3);
    check("after_pop_ready", in_ready, 1'b1);
    cyc(0, 0, 0, 1);

    // steady push/pop at count=2 across pointer wrap
    cyc(1, 32'h8C000100, 0, 0);
    cyc(1, 32'hAC000101, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1, rand_instr(), 1, 0);
      check("wrap_count", count, 3'd2);
    end
    cyc(0, 0, 0, 1);

    // illegal opcode
    cyc(1, 32'hFC000000, 0, 0);
    check("ill_type", out_type, 2'd3);
    check("ill_flag", out_illegal, 1'b1);
    check("ill_cnt", illegal_cnt, 16'(mdl_ilc));

    // flush at count=3 with a simultaneous push
    cyc(1, 32'h10000001, 0, 0);
    cyc(1, 32'h08000002, 0, 0);
    cyc(1, 32'h0D55AAAA, 1, 1);
    check("flush_count", count, 3'd0);
    check("flush_valid", out_valid, 1'b0);
    cyc(0, 0, 0, 0);

    // asynchronous reset mid-stream
    cyc(1, 32'h2009FFFF, 0, 0);
    cyc(1, 32'hFC000000, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    mdl_q.delete();
    mdl_ilc = 0;
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1, 32'h0C000003, 0, 0);
    check("post_reset_push", count, 3'd1);
    cyc(0, 0, 0, 1);

    // randomized traffic
    for (int k = 0; k < 800; k++)
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
    cyc(0, 0, 0, 1);

    // saturation of the illegal counter
    in_valid = 1'b1; in_instr = 32'hFC000000; out_ready = 1'b1; flush = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    mdl_ilc = (mdl_ilc + 65540 > 65535) ? 65535 : mdl_ilc + 65540;
    mdl_q.delete();
    mdl_q.push_back(32'hFC000000);
    check("ilc_saturated", illegal_cnt, 16'hFFFF);
    cyc(1, 32'hFC000000, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("ilc_survives_flush", illegal_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
